// File: rtl/i2c_bus_decoder_if.sv
// rtl/i2c_bus_decoder_if.sv - pin and event bundle between I2C pads, decoder and slave controller
interface i2c_bus_decoder_if;
    logic       scl;
    logic       sda_in;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_found;
    logic       rstart_found;
    logic       stop_found;
    logic       bus_busy;
    logic       addr_valid;
    logic [7:0] starting_byte;
    logic       address_match;
    logic       rw_mode;

    // Decoder side: consumes raw pins, produces clean events
    modport slave (
        input  scl,
        input  sda_in,
        output scl_rise,
        output scl_fall,
        output start_found,
        output rstart_found,
        output stop_found,
        output bus_busy,
        output addr_valid,
        output starting_byte,
        output address_match,
        output rw_mode
    );

    // Pad/controller side: drives raw pins, observes events
    modport master (
        output scl,
        output sda_in,
        input  scl_rise,
        input  scl_fall,
        input  start_found,
        input  rstart_found,
        input  stop_found,
        input  bus_busy,
        input  addr_valid,
        input  starting_byte,
        input  address_match,
        input  rw_mode
    );
endinterface

// File: rtl/i2c_bus_decoder.sv
// rtl/i2c_bus_decoder.sv - I2C slave front end: sync, optional glitch filter (I2C_DECODE_GLITCH_FILTER_EN), START/STOP and address decode
module i2c_bus_decoder #(
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3,
    parameter logic [6:0] SLAVE_ADDR  = 7'b1111000,
    parameter logic [6:0] ADDR_MASK   = 7'h7F
) (
    input  logic                  clk,
    input  logic                  n_rst,
    i2c_bus_decoder_if.slave      bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Synchroniser chains; reset to 1 so an idle bus looks idle from the start
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;

    // Shift raw pins through the synchroniser chains
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
        end
    end

    logic scl_f;
    logic sda_f;

`ifdef I2C_DECODE_GLITCH_FILTER_EN
    // Window = previous FILTER_LEN-1 synchronised samples plus the current one,
    // so the filtered line moves FILTER_LEN clocks after the synchroniser output.
    logic [FILTER_LEN-1:0] scl_win;
    logic [FILTER_LEN-1:0] sda_win;
    logic                  scl_filt_q;
    logic                  sda_filt_q;

    generate
        if (FILTER_LEN > 1) begin : g_hist
            logic [FILTER_LEN-2:0] scl_hist_q;
            logic [FILTER_LEN-2:0] sda_hist_q;

            assign scl_win = {scl_hist_q, scl_sync_q[SYNC_STAGES-1]};
            assign sda_win = {sda_hist_q, sda_sync_q[SYNC_STAGES-1]};

            // Keep the most recent FILTER_LEN-1 synchronised samples
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    scl_hist_q <= '1;
                    sda_hist_q <= '1;
                end else begin
                    scl_hist_q <= scl_win[FILTER_LEN-2:0];
                    sda_hist_q <= sda_win[FILTER_LEN-2:0];
                end
            end
        end else begin : g_nohist
            assign scl_win = scl_sync_q[SYNC_STAGES-1];
            assign sda_win = sda_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Filtered lines change only when the whole window agrees
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            if (&scl_win)       scl_filt_q <= 1'b1;
            else if (~|scl_win) scl_filt_q <= 1'b0;
            if (&sda_win)       sda_filt_q <= 1'b1;
            else if (~|sda_win) sda_filt_q <= 1'b0;
        end
    end

    assign scl_f = scl_filt_q;
    assign sda_f = sda_filt_q;
`else
    assign scl_f = scl_sync_q[SYNC_STAGES-1];
    assign sda_f = sda_sync_q[SYNC_STAGES-1];
`endif

    // One-cycle-delayed copies of the filtered lines for edge detection
    logic scl_prev_q;
    logic sda_prev_q;

    // Event registers
    logic scl_rise_q;
    logic scl_fall_q;
    logic start_q;
    logic rstart_q;
    logic stop_q;

    // FSM and address capture state
    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] byte_q, byte_d;
    logic       addr_valid_q, addr_valid_d;
    logic       match_q, match_d;
    logic       rw_q, rw_d;
    logic       busy_q;

    logic scl_rise_d;
    logic scl_fall_d;
    logic start_d;
    logic stop_d;
    logic rstart_d;
    logic scl_hi;

    // Edge and bus-condition detection; a simultaneous SCL change kills START/STOP
    always_comb begin
        scl_rise_d = scl_f & ~scl_prev_q;
        scl_fall_d = ~scl_f & scl_prev_q;
        scl_hi     = scl_f & scl_prev_q;
        start_d    = scl_hi & sda_prev_q & ~sda_f;
        stop_d     = scl_hi & ~sda_prev_q & sda_f;
        rstart_d   = start_d & (state_q != ST_IDLE);
    end

    // Next-state logic: START/STOP take priority over address shifting
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        byte_d       = byte_q;
        addr_valid_d = 1'b0;
        match_d      = match_q;
        rw_d         = rw_q;
        if (start_d) begin
            state_d = ST_ADDR;
            cnt_d   = 3'd0;
            byte_d  = 8'd0;
            match_d = 1'b0;
            rw_d    = 1'b0;
        end else if (stop_d) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            match_d = 1'b0;
            rw_d    = 1'b0;
        end else if (state_q == ST_ADDR && scl_rise_q) begin
            byte_d = {byte_q[6:0], sda_f};
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                state_d      = ST_DATA;
                addr_valid_d = 1'b1;
                match_d      = (((byte_d[7:1] ^ SLAVE_ADDR) & ADDR_MASK) == 7'd0);
                rw_d         = byte_d[0];
            end
        end
    end

    // Register line history, event pulses and FSM state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            scl_rise_q   <= 1'b0;
            scl_fall_q   <= 1'b0;
            start_q      <= 1'b0;
            rstart_q     <= 1'b0;
            stop_q       <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            byte_q       <= 8'd0;
            addr_valid_q <= 1'b0;
            match_q      <= 1'b0;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            scl_prev_q   <= scl_f;
            sda_prev_q   <= sda_f;
            scl_rise_q   <= scl_rise_d;
            scl_fall_q   <= scl_fall_d;
            start_q      <= start_d;
            rstart_q     <= rstart_d;
            stop_q       <= stop_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            byte_q       <= byte_d;
            addr_valid_q <= addr_valid_d;
            match_q      <= match_d;
            rw_q         <= rw_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign bus.scl_rise      = scl_rise_q;
    assign bus.scl_fall      = scl_fall_q;
    assign bus.start_found   = start_q;
    assign bus.rstart_found  = rstart_q;
    assign bus.stop_found    = stop_q;
    assign bus.bus_busy      = busy_q;
    assign bus.addr_valid    = addr_valid_q;
    assign bus.starting_byte = byte_q;
    assign bus.address_match = match_q;
    assign bus.rw_mode       = rw_q;

endmodule

// File: tb/tb_i2c_bus_decoder.sv
// tb/tb_i2c_bus_decoder.sv - directed self-checking bench for i2c_bus_decoder
module tb_i2c_bus_decoder;

    localparam int H = 8;
`ifdef I2C_DECODE_GLITCH_FILTER_EN
    localparam int LAT      = 2 + 3 + 1;
    localparam int GLITCH_S = 0;
`else
    localparam int LAT      = 2 + 1;
    localparam int GLITCH_S = 1;
`endif

    logic clk;
    logic n_rst;

    i2c_bus_decoder_if bus_a ();
    i2c_bus_decoder_if bus_b ();

    i2c_bus_decoder u_dut_a (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_a)
    );

    i2c_bus_decoder #(.ADDR_MASK(7'h7E)) u_dut_b (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int n_start = 0, n_rstart = 0, n_rs_pair = 0, n_stop = 0, n_rise = 0, n_av = 0;
    logic [7:0] cap_byte_a = 8'h00;
    logic       cap_match_a = 1'b0, cap_rw_a = 1'b0;
    logic       cap_match_b = 1'b0, cap_rw_b = 1'b0;

    always @(negedge clk) begin
        if (bus_a.start_found)  n_start++;
        if (bus_a.rstart_found) n_rstart++;
        if (bus_a.rstart_found && bus_a.start_found) n_rs_pair++;
        if (bus_a.stop_found)   n_stop++;
        if (bus_a.scl_rise)     n_rise++;
        if (bus_a.addr_valid) begin
            n_av++;
            cap_byte_a  = bus_a.starting_byte;
            cap_match_a = bus_a.address_match;
            cap_rw_a    = bus_a.rw_mode;
        end
        if (bus_b.addr_valid) begin
            cap_match_b = bus_b.address_match;
            cap_rw_b    = bus_b.rw_mode;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lines(input logic s, input logic d);
        bus_a.scl = s; bus_a.sda_in = d;
        bus_b.scl = s; bus_b.sda_in = d;
    endtask

    task automatic i2c_start();
        lines(bus_a.scl, 1'b1); hold(H);
        lines(1'b1, 1'b1);      hold(H);
        lines(1'b1, 1'b0);      hold(H);
        lines(1'b0, 1'b0);      hold(H);
    endtask

    task automatic send_bit(input logic b);
        lines(1'b0, b); hold(H);
        lines(1'b1, b); hold(H);
        lines(1'b0, b); hold(H);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
    endtask

    task automatic i2c_stop();
        lines(1'b0, 1'b0); hold(H);
        lines(1'b1, 1'b0); hold(H);
        lines(1'b1, 1'b1); hold(H);
    endtask

    int s0, r0, st0, rs0, rp0, av0;

    initial begin
        lines(1'b1, 1'b1);
        n_rst = 1'b0;
        hold(3);
        n_rst = 1'b1;
        hold(2 * H);

        // Reset release on an idle bus
        check("reset_outputs", {bus_a.scl_rise, bus_a.scl_fall, bus_a.start_found, bus_a.rstart_found,
                                bus_a.stop_found, bus_a.addr_valid, bus_a.address_match, bus_a.rw_mode}, 0);
        check("reset_busy", bus_a.bus_busy, 0);
        check("reset_byte", bus_a.starting_byte, 0);
        check("reset_no_events", n_start + n_stop + n_rise, 0);

        // START latency and one-cycle pulse width, then 0xF0 write
        s0 = n_start; r0 = n_rise; st0 = n_stop; av0 = n_av;
        lines(1'b1, 1'b0);
        hold(LAT - 1);
        check("start_early", bus_a.start_found, 0);
        hold(1);
        check("start_on_time", bus_a.start_found, 1);
        check("busy_after_start", bus_a.bus_busy, 1);
        hold(1);
        check("start_one_cycle", bus_a.start_found, 0);
        hold(H);
        lines(1'b0, 1'b0); hold(H);
        send_bits(8'hF0, 8);
        check("f0_start_count", n_start - s0, 1);
        check("f0_rise_count", n_rise - r0, 8);
        check("f0_av_count", n_av - av0, 1);
        check("f0_cap_byte", cap_byte_a, 8'hF0);
        check("f0_cap_match", cap_match_a, 1);
        check("f0_cap_rw", cap_rw_a, 0);
        check("f0_hold_match", bus_a.address_match, 1);
        check("f0_hold_byte", bus_a.starting_byte, 8'hF0);
        i2c_stop();
        check("f0_stop_count", n_stop - st0, 1);
        check("f0_match_cleared", bus_a.address_match, 0);
        check("f0_busy_cleared", bus_a.bus_busy, 0);
        check("f0_byte_held", bus_a.starting_byte, 8'hF0);

        // 0xF3 read: mask 7E matches, mask 7F does not
        av0 = n_av;
        i2c_start();
        send_bits(8'hF3, 8);
        check("f3_av_count", n_av - av0, 1);
        check("f3_a_match", cap_match_a, 0);
        check("f3_a_rw", cap_rw_a, 1);
        check("f3_b_match", cap_match_b, 1);
        check("f3_b_rw", cap_rw_b, 1);
        check("f3_b_hold", bus_b.address_match, 1);
        i2c_stop();

        // Repeated START after 4 address bits, then 0xF1
        s0 = n_start; rs0 = n_rstart; rp0 = n_rs_pair; av0 = n_av;
        i2c_start();
        send_bits(8'hF0, 4);
        check("rs_no_av_yet", n_av - av0, 0);
        i2c_start();
        send_bits(8'hF1, 8);
        check("rs_start_count", n_start - s0, 2);
        check("rs_rstart_count", n_rstart - rs0, 1);
        check("rs_pair", n_rs_pair - rp0, 1);
        check("rs_av_count", n_av - av0, 1);
        check("rs_cap_byte", cap_byte_a, 8'hF1);
        check("rs_cap_match", cap_match_a, 1);
        check("rs_cap_rw", cap_rw_a, 1);
        i2c_stop();

        // STOP mid-address: no addr_valid
        av0 = n_av;
        i2c_start();
        send_bits(8'hF0, 3);
        i2c_stop();
        check("midstop_no_av", n_av - av0, 0);
        check("midstop_idle", bus_a.bus_busy, 0);

        // Short SDA glitch while SCL high
        s0 = n_start; st0 = n_stop;
        lines(1'b1, 1'b0); hold(2);
        lines(1'b1, 1'b1); hold(2 * H);
        check("glitch2_start", n_start - s0, GLITCH_S);
        check("glitch2_stop", n_stop - st0, GLITCH_S);
        s0 = n_start; st0 = n_stop;
        lines(1'b1, 1'b0); hold(3);
        lines(1'b1, 1'b1); hold(2 * H);
        check("glitch3_start", n_start - s0, 1);
        check("glitch3_stop", n_stop - st0, 1);
        check("glitch_idle", bus_a.bus_busy, 0);

        // Reset after 5 address bits, then a clean transfer
        i2c_start();
        send_bits(8'hF0, 5);
        check("prereset_busy", bus_a.bus_busy, 1);
        n_rst = 1'b0;
        #1;
        check("rst_outputs", {bus_a.scl_rise, bus_a.scl_fall, bus_a.start_found, bus_a.rstart_found,
                              bus_a.stop_found, bus_a.bus_busy, bus_a.addr_valid, bus_a.address_match,
                              bus_a.rw_mode}, 0);
        check("rst_byte", bus_a.starting_byte, 0);
        lines(1'b1, 1'b1);
        hold(3);
        n_rst = 1'b1;
        hold(2 * H);
        check("postrst_idle", bus_a.bus_busy, 0);
        av0 = n_av;
        i2c_start();
        send_bits(8'hF0, 8);
        check("postrst_av", n_av - av0, 1);
        check("postrst_byte", cap_byte_a, 8'hF0);
        check("postrst_match", cap_match_a, 1);
        i2c_stop();
        check("postrst_busy", bus_a.bus_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
